// File: rtl/n64_ctrl_responder.sv
// n64_ctrl_responder: device-side Joybus responder that emulates a standard N64 controller.
// Decodes console command bytes on CTRL and answers info/poll requests through an open-drain pull-down.
module n64_ctrl_responder #(
    parameter int         CLKS_PER_US  = 4,
    parameter int         IDLE_CYC     = 255,
    parameter int         REPLY_GAP_US = 2,
    parameter logic [7:0] STATUS_BYTE  = 8'h02
) (
    input  logic        CTRL_CLK,
    input  logic        CTRL_RST,
    input  logic        CTRL_i,
    output logic        CTRL_oe_o,
    input  logic        enable_i,
    input  logic [31:0] ctrl_data_i,
    output logic        busy_o,
    output logic        poll_o,
    output logic [7:0]  cmd_o,
    output logic        cmd_err_o
);

    localparam int GAP_CYC  = REPLY_GAP_US * CLKS_PER_US;
    localparam int BIT_CYC  = 4 * CLKS_PER_US;
    localparam int STOP_CYC = 2 * CLKS_PER_US;
    localparam int STOP_MAX = 3 * CLKS_PER_US;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_CMD_RD,
        ST_CMD_STOP,
        ST_GAP,
        ST_TX,
        ST_TX_STOP
    } state_t;

    state_t      state, state_d;
    logic [2:0]  hist;
    logic        fall, rise;
    logic [7:0]  cnt, cnt_d;
    logic [7:0]  low_cnt, low_cnt_d;
    logic [7:0]  cmd_sr, cmd_sr_d;
    logic [3:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  tmr, tmr_d;
    logic [31:0] tx_sr, tx_sr_d;
    logic [5:0]  tx_left, tx_left_d;
    logic        oe_d, busy_d, poll_d, cmd_err_d;
    logic [7:0]  cmd_d;

    // Poll words go out bit 0 first; the shifter always sends its MSB, so reverse on load.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    assign fall = hist[2] & ~hist[1];
    assign rise = ~hist[2] & hist[1];

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state;
        low_cnt_d = low_cnt;
        cmd_sr_d  = cmd_sr;
        bit_cnt_d = bit_cnt;
        tmr_d     = tmr;
        tx_sr_d   = tx_sr;
        tx_left_d = tx_left;
        busy_d    = busy_o;
        poll_d    = 1'b0;
        cmd_err_d = 1'b0;
        cmd_d     = cmd_o;
        if (fall || rise)      cnt_d = '0;
        else if (cnt != 8'hFF) cnt_d = cnt + 8'd1;
        else                   cnt_d = cnt;

        unique case (state)
            ST_WAIT_IDLE: begin
                if (fall && cnt >= 8'(IDLE_CYC) && enable_i) begin
                    state_d   = ST_CMD_RD;
                    cmd_sr_d  = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_CMD_RD: begin
                if (!enable_i) begin
                    state_d = ST_WAIT_IDLE;
                end else if (cnt == 8'hFF) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end else if (rise) begin
                    low_cnt_d = cnt;
                end else if (fall) begin
                    cmd_sr_d  = {cmd_sr[6:0], (low_cnt < cnt)};
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) state_d = ST_CMD_STOP;
                end
            end
            ST_CMD_STOP: begin
                if (!enable_i) begin
                    state_d = ST_WAIT_IDLE;
                end else if (cnt > 8'(STOP_MAX)) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end else if (rise) begin
                    cmd_d = cmd_sr;
                    tmr_d = '0;
                    case (cmd_sr)
                        8'h00, 8'hFF: begin
                            tx_sr_d   = {8'h05, 8'h00, STATUS_BYTE, 8'h00};
                            tx_left_d = 6'd24;
                            busy_d    = 1'b1;
                            state_d   = ST_GAP;
                        end
                        8'h01: begin
                            tx_sr_d   = bit_reverse(ctrl_data_i);
                            tx_left_d = 6'd32;
                            busy_d    = 1'b1;
                            poll_d    = 1'b1;
                            state_d   = ST_GAP;
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                            state_d   = ST_WAIT_IDLE;
                        end
                    endcase
                end
            end
            ST_GAP, ST_TX, ST_TX_STOP: begin
                if (!enable_i) begin
                    busy_d  = 1'b0;
                    state_d = ST_WAIT_IDLE;
                end else if (state == ST_GAP) begin
                    if (tmr == 8'(GAP_CYC - 1)) begin
                        tmr_d   = '0;
                        state_d = ST_TX;
                    end else begin
                        tmr_d = tmr + 8'd1;
                    end
                end else if (state == ST_TX) begin
                    if (tmr == 8'(BIT_CYC - 1)) begin
                        tmr_d     = '0;
                        tx_sr_d   = {tx_sr[30:0], 1'b0};
                        tx_left_d = tx_left - 6'd1;
                        if (tx_left == 6'd1) state_d = ST_TX_STOP;
                    end else begin
                        tmr_d = tmr + 8'd1;
                    end
                end else begin
                    if (tmr == 8'(STOP_CYC - 1)) begin
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        tmr_d = tmr + 8'd1;
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        // Drive is derived from the next state so the registered pad enable lines up with it exactly.
        oe_d = 1'b0;
        if (state_d == ST_TX_STOP)
            oe_d = 1'b1;
        else if (state_d == ST_TX)
            oe_d = tmr_d < (tx_sr_d[31] ? 8'(CLKS_PER_US) : 8'(3 * CLKS_PER_US));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) begin
            state     <= ST_WAIT_IDLE;
            hist      <= 3'b111;   // idle-high line, so leaving reset never looks like a falling edge
            cnt       <= '0;
            low_cnt   <= '0;
            cmd_sr    <= '0;
            bit_cnt   <= '0;
            tmr       <= '0;
            tx_sr     <= '0;
            tx_left   <= '0;
            CTRL_oe_o <= 1'b0;
            busy_o    <= 1'b0;
            poll_o    <= 1'b0;
            cmd_o     <= 8'h00;
            cmd_err_o <= 1'b0;
        end else begin
            state     <= state_d;
            hist      <= {hist[1:0], CTRL_i};
            cnt       <= cnt_d;
            low_cnt   <= low_cnt_d;
            cmd_sr    <= cmd_sr_d;
            bit_cnt   <= bit_cnt_d;
            tmr       <= tmr_d;
            tx_sr     <= tx_sr_d;
            tx_left   <= tx_left_d;
            CTRL_oe_o <= oe_d;
            busy_o    <= busy_d;
            poll_o    <= poll_d;
            cmd_o     <= cmd_d;
            cmd_err_o <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_n64_ctrl_responder.sv
// tb_n64_ctrl_responder: console-side stimulus with a line-level sniffer model and reply scoreboard.
`timescale 1ns/1ps
module tb_n64_ctrl_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        con_low;
    logic        enable;
    logic [31:0] data;
    logic        ctrl_line;
    logic        oe, busy, poll, err;
    logic [7:0]  cmd;

    typedef struct {
        int          nbits;
        logic [31:0] bits;      // bits[k] = k-th bit seen on the line
        int          stop_cyc;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int poll_cnt = 0;
    int err_cnt = 0;
    int oe_cycles = 0;
    int replies_done = 0;

    bit          mon_active = 1'b0;
    bit          mon_prev_oe = 1'b0;
    bit          discard = 1'b0;
    int          mon_low, mon_high, mon_prev_low, mon_bits, mon_terr, mon_first;
    logic        mon_busy0;
    logic [31:0] mon_word;

    assign ctrl_line = ~(con_low | oe);

    n64_ctrl_responder dut (
        .CTRL_CLK    (clk),
        .CTRL_RST    (rst),
        .CTRL_i      (ctrl_line),
        .CTRL_oe_o   (oe),
        .enable_i    (enable),
        .ctrl_data_i (data),
        .busy_o      (busy),
        .poll_o      (poll),
        .cmd_o       (cmd),
        .cmd_err_o   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev24(input logic [23:0] v);
        logic [31:0] r = '0;
        for (int k = 0; k < 24; k++) r[k] = v[23-k];
        return r;
    endfunction

    task automatic finish_reply(input int stop_low);
        exp_t e;
        int   lat;
        if (sb_q.size() == 0) begin
            check("unexpected_reply", 32'd1, 32'd0);
        end else begin
            e   = sb_q.pop_front();
            lat = mon_first - e.stop_cyc;
            check("reply_len", mon_bits, e.nbits);
            check("reply_data", mon_word, e.bits);
            check("stop_len", stop_low, 8);
            check("bit_timing_errs", mon_terr, 0);
            check("latency", (lat >= 10 && lat <= 12) ? 11 : lat, 11);
            check("busy_at_tx", mon_busy0, 1'b1);
        end
        replies_done++;
    endtask

    // Sniffer model: classifies each low pulse of the responder's drive (4 = '1', 12 = '0', 8 = stop).
    always @(negedge clk) begin
        if (poll) poll_cnt++;
        if (err)  err_cnt++;
        if (oe) begin
            oe_cycles++;
            if (!mon_prev_oe) begin
                if (!mon_active) begin
                    mon_active = 1'b1;
                    mon_bits   = 0;
                    mon_word   = '0;
                    mon_terr   = 0;
                    mon_first  = cyc;
                    mon_busy0  = busy;
                end else if (mon_high != 16 - mon_prev_low) begin
                    mon_terr++;
                end
                mon_low = 0;
            end
            mon_low++;
        end else begin
            if (mon_prev_oe && mon_active) begin
                if (mon_low == 4 || mon_low == 12) begin
                    if (mon_bits < 32) mon_word[mon_bits] = (mon_low == 4);
                    mon_bits++;
                    mon_prev_low = mon_low;
                    mon_high     = 0;
                end else begin
                    if (!discard) finish_reply(mon_low);
                    mon_active = 1'b0;
                end
            end
            if (mon_active) begin
                mon_high++;
                if (mon_high > 20) begin
                    if (!discard) check("reply_truncated", 32'd1, 32'd0);
                    mon_active = 1'b0;
                end
            end
        end
        mon_prev_oe = oe;
    end

    task automatic hold(input logic low, input int n);
        con_low = low;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b, input int stop_low, output int stop_cyc);
        for (int i = 7; i >= 0; i--) begin
            hold(1'b1, b[i] ? 4 : 12);
            hold(1'b0, b[i] ? 12 : 4);
        end
        hold(1'b1, stop_low);
        con_low  = 1'b0;
        stop_cyc = cyc;
    endtask

    task automatic send_and_expect(input logic [7:0] b, input int nbits, input logic [31:0] bits);
        int   sc;
        exp_t e;
        send_cmd(b, 4, sc);
        e.nbits    = nbits;
        e.bits     = bits;
        e.stop_cyc = sc;
        sb_q.push_back(e);
    endtask

    task automatic wait_reply(input string tag);
        int start = replies_done;
        for (int i = 0; i < 3000 && replies_done == start; i++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_done"}, replies_done - start, 1);
    endtask

    task automatic wait_bit_start(input int n, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            #1;
            found = mon_active && mon_bits == n && oe && mon_low == 1;
        end
        check({tag, "_reached"}, found, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int p0, e0, o0, sc;
        rst     = 1'b1;
        con_low = 1'b0;
        enable  = 1'b1;
        data    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_poll", poll, 1'b0);
        check("rst_cmd", cmd, 8'h00);
        check("rst_err", err, 1'b0);
        rst = 1'b0;

        // Poll reply decoded bit 0 first
        hold(1'b0, 300);
        data = 32'h7F80_1001;
        p0 = poll_cnt;
        send_and_expect(8'h01, 32, 32'h7F80_1001);
        wait_reply("poll1");
        check("poll1_pulse", poll_cnt - p0, 1);
        check("poll1_cmd", cmd, 8'h01);
        check("poll1_busy_end", busy, 1'b0);

        // Info replies for 0xFF and 0x00
        hold(1'b0, 300);
        p0 = poll_cnt;
        send_and_expect(8'hFF, 24, rev24(24'h05_00_02));
        wait_reply("info_ff");
        check("info_ff_cmd", cmd, 8'hFF);
        check("info_ff_nopoll", poll_cnt - p0, 0);
        hold(1'b0, 300);
        send_and_expect(8'h00, 24, rev24(24'h05_00_02));
        wait_reply("info_00");
        check("info_00_cmd", cmd, 8'h00);

        // Unknown command
        hold(1'b0, 300);
        e0 = err_cnt; o0 = oe_cycles; p0 = poll_cnt;
        send_cmd(8'h02, 4, sc);
        hold(1'b0, 40);
        check("bad_cmd_err", err_cnt - e0, 1);
        check("bad_cmd_nodrive", oe_cycles - o0, 0);
        check("bad_cmd_cmd", cmd, 8'h02);
        check("bad_cmd_nopoll", poll_cnt - p0, 0);

        hold(1'b0, 300);
        data = 32'hA5C3_0F18;
        send_and_expect(8'h01, 32, 32'hA5C3_0F18);
        wait_reply("after_err");

        // Too soon after activity: ignored; then answered after full idle
        hold(1'b0, 100);
        e0 = err_cnt; o0 = oe_cycles; p0 = poll_cnt;
        send_cmd(8'h01, 4, sc);
        hold(1'b0, 40);
        check("early_nodrive", oe_cycles - o0, 0);
        check("early_nopoll", poll_cnt - p0, 0);
        check("early_noerr", err_cnt - e0, 0);
        hold(1'b0, 300);
        data = 32'h1234_5678;
        send_and_expect(8'h01, 32, 32'h1234_5678);
        wait_reply("late");

        // Stop bit held low too long
        hold(1'b0, 300);
        e0 = err_cnt; o0 = oe_cycles;
        send_cmd(8'h01, 20, sc);
        hold(1'b0, 40);
        check("long_stop_err", err_cnt - e0, 1);
        check("long_stop_nodrive", oe_cycles - o0, 0);

        // enable_i drop at reply bit 10
        hold(1'b0, 300);
        discard = 1'b1;
        data = 32'hFFFF_0000;
        send_cmd(8'h01, 4, sc);
        wait_bit_start(10, "abort_bit10");
        @(posedge clk);
        #1;
        enable = 1'b0;
        p0 = poll_cnt; e0 = err_cnt;
        @(posedge clk);
        @(negedge clk);
        check("abort_oe", oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        hold(1'b0, 40);
        check("abort_no_pulses", (poll_cnt - p0) + (err_cnt - e0), 0);
        enable = 1'b1;

        // Reset mid-reply
        hold(1'b0, 300);
        send_cmd(8'h01, 4, sc);
        wait_bit_start(5, "rst_bit5");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_oe", oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_poll", poll, 1'b0);
        check("midrst_cmd", cmd, 8'h00);
        check("midrst_err", err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 50);
        discard = 1'b0;

        // Input word changes after latch must not leak into the reply
        hold(1'b0, 300);
        data = 32'hFFFF_FFFF;
        send_and_expect(8'h01, 32, 32'hFFFF_FFFF);
        hold(1'b0, 5);
        data = 32'h0000_0000;
        wait_reply("latched");

        hold(1'b0, 20);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
